// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam int unsigned RAM_LATENCY = 2;

    typedef struct packed {
        logic valid;
        logic id;
        logic we;
    } tag_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side signals of the arbiter, bundled with modports.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) ();

    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              lock0, lock1;
    logic              gnt0, gnt1;
    logic              rsp_valid0, rsp_valid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    // Arbiter side.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        output gnt0, gnt1, rsp_valid0, rsp_valid1, rdata0, rdata1,
        output ram_addr, ram_din, ram_we,
        input  ram_dout
    );

    // Requesters plus RAM side.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        input  gnt0, gnt1, rsp_valid0, rsp_valid1, rdata0, rdata1,
        input  ram_addr, ram_din, ram_we,
        output ram_dout
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin grant generator; the pointer moves to the other
// requester after each grant taken while advance is high.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic gnt0,
    output logic gnt1
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt0  = req0 && (!req1 || !ptr_q);
        gnt1  = req1 && (!req0 || ptr_q);
        ptr_d = ptr_q;
        if (advance) begin
            if (gnt0) begin
                ptr_d = 1'b1;
            end else if (gnt1) begin
                ptr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (0) and
// data access (1); round-robin with lock, fixed 2-cycle response latency.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic              rr_gnt0, rr_gnt1, rr_advance;
    logic              gnt0, gnt1, accept;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_we_q, ram_we_d;
    tag_t              tag_d;
    tag_t              tag_q [RAM_LATENCY];
    tag_t              tag_out;
    logic              rsp0, rsp1;

    // Pointer is frozen while a requester owns the RAM.
    assign rr_advance = (state_q == IDLE) && !rst;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req0    (bus.req0),
        .req1    (bus.req1),
        .advance (rr_advance),
        .gnt0    (rr_gnt0),
        .gnt1    (rr_gnt1)
    );

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    gnt0 = rr_gnt0;
                    gnt1 = rr_gnt1;
                    if (gnt0 && bus.lock0) begin
                        state_d = OWN0;
                    end else if (gnt1 && bus.lock1) begin
                        state_d = OWN1;
                    end
                end
                OWN0: begin
                    gnt0 = bus.req0;
                    if (!bus.lock0) state_d = IDLE;
                end
                OWN1: begin
                    gnt1 = bus.req1;
                    if (!bus.lock1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        accept     = gnt0 || gnt1;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        if (gnt1) begin
            ram_we_d   = bus.we1;
            ram_addr_d = bus.addr1;
            ram_din_d  = bus.wdata1;
        end else if (gnt0) begin
            ram_we_d   = bus.we0;
            ram_addr_d = bus.addr0;
            ram_din_d  = bus.wdata0;
        end
        tag_d.valid = accept;
        tag_d.id    = gnt1 ? REQ_DM : REQ_IF;
        tag_d.we    = gnt1 ? bus.we1 : bus.we0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            tag_q[0]   <= tag_d;
            for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out = tag_q[RAM_LATENCY-1];
    assign rsp0    = tag_out.valid && (tag_out.id == REQ_IF) && !rst;
    assign rsp1    = tag_out.valid && (tag_out.id == REQ_DM) && !rst;

    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.rsp_valid0 = rsp0;
    assign bus.rsp_valid1 = rsp1;
    assign bus.rdata0     = (rsp0 && !tag_out.we) ? bus.ram_dout : '0;
    assign bus.rdata1     = (rsp1 && !tag_out.we) ? bus.ram_dout : '0;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_din    = ram_din_q;
    assign bus.ram_we     = ram_we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM model.
module tb_ram_arbiter;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ram_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    ram_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: 1-cycle registered read, no reset; pl_* preloads words.
    logic [31:0] mem [256];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.lock0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.lock1 = 0;
    endtask

    task automatic do_reset;
        rst = 1;
        clear_reqs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        clear_reqs();
        bus.req0 = 1;
        bus.req1 = 1;
        #2;
        checks++; if (bus.gnt0 !== 1'b0) begin
            $display("FAIL reset_gnt0 got=%0b exp=0", bus.gnt0); failures++; end
        checks++; if (bus.gnt1 !== 1'b0) begin
            $display("FAIL reset_gnt1 got=%0b exp=0", bus.gnt1); failures++; end
        tick();
        tick();
        clear_reqs();
        rst = 0;
        #2;
        checks++; if (bus.ram_we !== 1'b0) begin
            $display("FAIL reset_ram_we got=%0b exp=0", bus.ram_we); failures++; end
        checks++; if (bus.ram_addr !== 8'h00) begin
            $display("FAIL reset_ram_addr got=%h exp=00", bus.ram_addr); failures++; end
        checks++; if (bus.ram_din !== 32'h0) begin
            $display("FAIL reset_ram_din got=%h exp=0", bus.ram_din); failures++; end
        checks++; if (bus.rsp_valid0 !== 1'b0 || bus.rsp_valid1 !== 1'b0) begin
            $display("FAIL reset_rsp got=%0b%0b exp=00", bus.rsp_valid0, bus.rsp_valid1);
            failures++; end
        checks++; if (bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin
            $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.rdata0, bus.rdata1);
            failures++; end
    endtask

    // Runs in the first cycle after reset release.
    task automatic test_read_preload;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'd5;
        #2;
        checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            $display("FAIL pre_gnt got=%0b%0b exp=10", bus.gnt0, bus.gnt1); failures++; end
        tick();
        clear_reqs();
        #2;
        checks++; if (bus.rsp_valid0 !== 1'b0 || bus.ram_addr !== 8'd5) begin
            $display("FAIL pre_c2 got rsp=%0b addr=%0d exp rsp=0 addr=5",
                     bus.rsp_valid0, bus.ram_addr); failures++; end
        tick();
        #2;
        checks++; if (bus.rsp_valid0 !== 1'b1 || bus.rdata0 !== 32'hDEADBEEF) begin
            $display("FAIL pre_rsp got v=%0b d=%h exp v=1 d=deadbeef",
                     bus.rsp_valid0, bus.rdata0); failures++; end
        checks++; if (bus.rsp_valid1 !== 1'b0) begin
            $display("FAIL pre_rsp1 got=%0b exp=0", bus.rsp_valid1); failures++; end
        tick();
        #2;
        checks++; if (bus.rsp_valid0 !== 1'b0 || bus.rsp_valid1 !== 1'b0) begin
            $display("FAIL pre_c4 got=%0b%0b exp=00", bus.rsp_valid0, bus.rsp_valid1);
            failures++; end
    endtask

    task automatic test_round_robin;
        logic e0, e1, r0, r1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            clear_reqs();
            if (i < 4) begin
                bus.req0 = 1; bus.addr0 = 8'd10;
                bus.req1 = 1; bus.addr1 = 8'd11;
            end
            #2;
            e0 = (i < 4) && (i % 2 == 0);
            e1 = (i < 4) && (i % 2 == 1);
            r0 = (i >= 2) && (i % 2 == 0);
            r1 = (i >= 2) && (i % 2 == 1);
            checks++; if (bus.gnt0 !== e0 || bus.gnt1 !== e1) begin
                $display("FAIL rr_gnt c%0d got=%0b%0b exp=%0b%0b", i, bus.gnt0, bus.gnt1, e0, e1);
                failures++; end
            checks++; if (bus.rsp_valid0 !== r0 || bus.rsp_valid1 !== r1) begin
                $display("FAIL rr_rsp c%0d got=%0b%0b exp=%0b%0b", i,
                         bus.rsp_valid0, bus.rsp_valid1, r0, r1); failures++; end
            if (r0) begin
                checks++; if (bus.rdata0 !== 32'hA0A0A0A0) begin
                    $display("FAIL rr_rdata0 c%0d got=%h exp=a0a0a0a0", i, bus.rdata0);
                    failures++; end
            end
            if (r1) begin
                checks++; if (bus.rdata1 !== 32'hB1B1B1B1) begin
                    $display("FAIL rr_rdata1 c%0d got=%h exp=b1b1b1b1", i, bus.rdata1);
                    failures++; end
            end
            tick();
        end
    endtask

    task automatic test_write_then_read;
        do_reset();
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'd7; bus.wdata1 = 32'h12345678;
        #2;
        checks++; if (bus.gnt1 !== 1'b1) begin
            $display("FAIL raw_gnt1 got=%0b exp=1", bus.gnt1); failures++; end
        tick();
        clear_reqs();
        bus.req0 = 1; bus.addr0 = 8'd7;
        #2;
        checks++; if (bus.gnt0 !== 1'b1) begin
            $display("FAIL raw_gnt0 got=%0b exp=1", bus.gnt0); failures++; end
        tick();
        clear_reqs();
        #2;
        checks++; if (bus.rsp_valid1 !== 1'b1 || bus.rdata1 !== 32'h0 || bus.rsp_valid0 !== 1'b0)
        begin
            $display("FAIL raw_wrsp got v1=%0b d1=%h v0=%0b exp v1=1 d1=0 v0=0",
                     bus.rsp_valid1, bus.rdata1, bus.rsp_valid0); failures++; end
        tick();
        #2;
        checks++; if (bus.rsp_valid0 !== 1'b1 || bus.rdata0 !== 32'h12345678) begin
            $display("FAIL raw_rrsp got v=%0b d=%h exp v=1 d=12345678",
                     bus.rsp_valid0, bus.rdata0); failures++; end
        tick();
    endtask

    task automatic test_back_to_back;
        do_reset();
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'd9; bus.wdata1 = 32'h11111111;
        tick();
        clear_reqs();
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'd9; bus.wdata0 = 32'h22222222;
        #2;
        checks++; if (bus.gnt0 !== 1'b1) begin
            $display("FAIL b2b_gnt0 got=%0b exp=1", bus.gnt0); failures++; end
        tick();
        clear_reqs();
        bus.req1 = 1; bus.addr1 = 8'd9;
        #2;
        checks++; if (bus.gnt1 !== 1'b1 || bus.rsp_valid1 !== 1'b1) begin
            $display("FAIL b2b_c3 got gnt1=%0b rsp1=%0b exp 1 1", bus.gnt1, bus.rsp_valid1);
            failures++; end
        tick();
        clear_reqs();
        #2;
        checks++; if (bus.rsp_valid0 !== 1'b1 || bus.rdata0 !== 32'h0) begin
            $display("FAIL b2b_c4 got v0=%0b d0=%h exp 1 0", bus.rsp_valid0, bus.rdata0);
            failures++; end
        tick();
        #2;
        checks++; if (bus.rsp_valid1 !== 1'b1 || bus.rdata1 !== 32'h22222222) begin
            $display("FAIL b2b_rd got v=%0b d=%h exp v=1 d=22222222",
                     bus.rsp_valid1, bus.rdata1); failures++; end
        tick();
    endtask

    task automatic test_lock;
        logic [4:0] e0;
        logic [4:0] e1;
        e0 = 5'b10000;
        e1 = 5'b01110;
        do_reset();
        // Single grant to requester 0 moves the pointer to requester 1.
        bus.req0 = 1;
        #2;
        checks++; if (bus.gnt0 !== 1'b1) begin
            $display("FAIL lock_pre got=%0b exp=1", bus.gnt0); failures++; end
        tick();
        for (int c = 1; c <= 4; c++) begin
            bus.req0  = 1; bus.addr0 = 8'd3; bus.lock0 = (c == 1);
            bus.req1  = (c < 4); bus.addr1 = 8'd4; bus.lock1 = (c < 3);
            #2;
            checks++; if (bus.gnt0 !== e0[c] || bus.gnt1 !== e1[c]) begin
                $display("FAIL lock_c%0d got=%0b%0b exp=%0b%0b", c, bus.gnt0, bus.gnt1,
                         e0[c], e1[c]); failures++; end
            tick();
        end
        clear_reqs();
        bus.req0 = 1; bus.req1 = 1;
        #2;
        checks++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b1) begin
            $display("FAIL lock_after got=%0b%0b exp=01", bus.gnt0, bus.gnt1); failures++; end
        tick();
        clear_reqs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'd20; bus.wdata1 = 32'hCAFEF00D;
        #2;
        checks++; if (bus.gnt1 !== 1'b1) begin
            $display("FAIL rmid_gnt1 got=%0b exp=1", bus.gnt1); failures++; end
        tick();
        clear_reqs();
        rst = 1;
        #2;
        checks++; if (bus.rsp_valid1 !== 1'b0 || bus.gnt0 !== 1'b0) begin
            $display("FAIL rmid_rst got rsp1=%0b gnt0=%0b exp 0 0", bus.rsp_valid1, bus.gnt0);
            failures++; end
        tick();
        rst = 0;
        bus.req0 = 1; bus.addr0 = 8'd20;
        #2;
        checks++; if (bus.gnt0 !== 1'b1 || bus.ram_we !== 1'b0 || bus.rsp_valid1 !== 1'b0) begin
            $display("FAIL rmid_c3 got gnt0=%0b we=%0b rsp1=%0b exp 1 0 0",
                     bus.gnt0, bus.ram_we, bus.rsp_valid1); failures++; end
        checks++; if (mem[20] !== 32'hCAFEF00D) begin
            $display("FAIL rmid_mem got=%h exp=cafef00d", mem[20]); failures++; end
        tick();
        clear_reqs();
        #2;
        checks++; if (bus.ram_we !== 1'b0 || bus.rsp_valid0 !== 1'b0 || bus.rsp_valid1 !== 1'b0)
        begin
            $display("FAIL rmid_c4 got we=%0b rsp=%0b%0b exp 0 00",
                     bus.ram_we, bus.rsp_valid0, bus.rsp_valid1); failures++; end
        tick();
        #2;
        checks++; if (bus.rsp_valid0 !== 1'b1 || bus.rdata0 !== 32'hCAFEF00D ||
                      bus.rsp_valid1 !== 1'b0) begin
            $display("FAIL rmid_rd got v0=%0b d0=%h v1=%0b exp 1 cafef00d 0",
                     bus.rsp_valid0, bus.rdata0, bus.rsp_valid1); failures++; end
        tick();
    endtask

    task automatic test_idle;
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (bus.ram_we !== 1'b0 || bus.rsp_valid0 !== 1'b0 || bus.rsp_valid1 !== 1'b0)
                bad++;
            tick();
        end
        checks++; if (bad != 0) begin
            $display("FAIL idle_quiet got=%0d active cycles exp=0", bad); failures++; end
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'd30; bus.wdata1 = 32'h55AA55AA;
        #2;
        checks++; if (bus.gnt1 !== 1'b1) begin
            $display("FAIL idle_gnt1 got=%0b exp=1", bus.gnt1); failures++; end
        tick();
        clear_reqs();
        #2;
        checks++; if (bus.ram_we !== 1'b1 || bus.ram_din !== 32'h55AA55AA) begin
            $display("FAIL idle_ram got we=%0b din=%h exp 1 55aa55aa", bus.ram_we, bus.ram_din);
            failures++; end
        tick();
        #2;
        checks++; if (bus.rsp_valid1 !== 1'b1 || bus.rdata1 !== 32'h0 ||
                      bus.rsp_valid0 !== 1'b0) begin
            $display("FAIL idle_wrsp got v1=%0b d1=%h v0=%0b exp 1 0 0",
                     bus.rsp_valid1, bus.rdata1, bus.rsp_valid0); failures++; end
        checks++; if (mem[30] !== 32'h55AA55AA) begin
            $display("FAIL idle_mem got=%h exp=55aa55aa", mem[30]); failures++; end
        tick();
    endtask

    initial begin
        logic [7:0]  pa [4];
        logic [31:0] pd [4];
        pa[0] = 8'd5;  pd[0] = 32'hDEADBEEF;
        pa[1] = 8'd7;  pd[1] = 32'h0BAD0BAD;
        pa[2] = 8'd10; pd[2] = 32'hA0A0A0A0;
        pa[3] = 8'd11; pd[3] = 32'hB1B1B1B1;
        rst = 1;
        clear_reqs();
        bus.ram_dout = '0;
        pl_en = 0; pl_addr = '0; pl_data = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            pl_en = 1; pl_addr = pa[i]; pl_data = pd[i];
            tick();
        end
        pl_en = 0;
        test_reset();
        test_read_preload();
        test_round_robin();
        test_write_then_read();
        test_back_to_back();
        test_lock();
        test_reset_mid();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
